// File: rtl/nf_10g_tx_metadata_if.sv
// nf_10g_tx_metadata_if: AXI-Stream bundle shared by the slave and master sides of the tx metadata block
interface nf_10g_tx_metadata_if #(
   parameter int DATA_WIDTH  = 64,
   parameter int TUSER_WIDTH = 128
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic [TUSER_WIDTH-1:0]  tuser;
   logic                    tvalid;
   logic                    tready;
   logic                    tlast;
   modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
   modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf_10g_tx_metadata.sv
// nf_10g_tx_metadata: forwards packets addressed to this port toward the MAC, sinks the rest, and logs one stat record per packet
module nf_10g_tx_metadata #(
   parameter int C_M_AXIS_DATA_WIDTH  = 64,
   parameter int C_S_AXIS_DATA_WIDTH  = 64,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int META_DATA_WIDTH      = 30
) (
   input  logic                       axis_aclk,
   input  logic                       axis_resetn,
   nf_10g_tx_metadata_if.slave        s_axis,
   nf_10g_tx_metadata_if.master       m_axis,
   input  logic                       stat_fifo_full,
   output logic [META_DATA_WIDTH-1:0] stat_fifo_dout,
   output logic                       stat_fifo_wren,
   input  logic [7:0]                 dst_port_num
);
   localparam int KW = (C_S_AXIS_DATA_WIDTH < C_M_AXIS_DATA_WIDTH ? C_S_AXIS_DATA_WIDTH : C_M_AXIS_DATA_WIDTH) / 8;
   typedef enum logic [1:0] {IDLE, SEND, DROP, STAT} state_t;
   state_t      state;
   logic [15:0] cnt, len, pc, cnt_nx, len_nx;
   logic [16:0] sum;
   logic [7:0]  mask;
   logic        match, start, pass, sink, acc, drop, drop_nx, mis;
   always_comb begin
      mask = dst_port_num == 8'd1 ? 8'h04 : dst_port_num == 8'd2 ? 8'h10 : dst_port_num == 8'd3 ? 8'h40 : 8'h01;
      match = |(s_axis.tuser[31:24] & mask);
      start = axis_resetn && state == IDLE && !stat_fifo_full && s_axis.tvalid;
      pass = (start && match) || state == SEND;
      sink = (start && !match) || state == DROP;
      s_axis.tready = pass ? m_axis.tready : sink;
      m_axis.tvalid = pass && s_axis.tvalid;
      m_axis.tdata = pass ? s_axis.tdata : '0;
      m_axis.tkeep = pass ? s_axis.tkeep : '0;
      m_axis.tlast = pass && s_axis.tlast;
      m_axis.tuser = {C_S_AXIS_TUSER_WIDTH{1'b0}};
      acc = s_axis.tvalid && s_axis.tready;
      pc = '0;
      for (int i = 0; i < KW; i++) pc = pc + 16'(s_axis.tkeep[i]);
      sum = {1'b0, cnt} + {1'b0, pc};
      cnt_nx = state == IDLE ? pc : sum[16] ? 16'hFFFF : sum[15:0];
      len_nx = state == IDLE ? s_axis.tuser[15:0] : len;
      drop_nx = state == IDLE ? !match : drop;
      mis = cnt_nx != len_nx;
   end
   // the record is built from next-state values so it is ready in the STAT cycle
   always_ff @(posedge axis_aclk or negedge axis_resetn)
      if (!axis_resetn) begin
         state <= IDLE;
         cnt <= '0;
         len <= '0;
         drop <= 1'b0;
         stat_fifo_wren <= 1'b0;
         stat_fifo_dout <= '0;
      end else begin
         stat_fifo_wren <= acc && s_axis.tlast;
         if (acc) begin
            cnt <= cnt_nx;
            len <= len_nx;
            drop <= drop_nx;
         end
         if (acc && s_axis.tlast)
            stat_fifo_dout <= META_DATA_WIDTH'({10'h0, cnt_nx[15] ? 15'h7FFF : cnt_nx[14:0], 2'b00, mis, drop_nx, !drop_nx});
         state <= state == STAT ? IDLE : acc && s_axis.tlast ? STAT : acc && state == IDLE ? (match ? SEND : DROP) : state;
      end
endmodule

// File: tb/tb_nf_10g_tx_metadata.sv
// tb_nf_10g_tx_metadata: directed and randomized checks of forwarding, dropping and stat records against a packet-level model
module tb_nf_10g_tx_metadata;
   localparam int DW = 64, UW = 128, MW = 30, KW = DW / 8;
   typedef struct {logic [DW-1:0] d; logic [KW-1:0] k; logic l;} beat_t;
   logic axis_aclk = 0, axis_resetn = 0, stat_fifo_full = 0, stat_fifo_wren;
   logic [MW-1:0] stat_fifo_dout;
   logic [7:0] dst_port_num = 0;
   int n_cmp = 0, n_err = 0, cyc = 0;
   beat_t exp_q[$];
   logic [MW-1:0] rec_q[$];
   int wren_hist[$];
   always #5 axis_aclk = ~axis_aclk;
   always @(posedge axis_aclk) cyc <= cyc + 1;
   nf_10g_tx_metadata_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_axis ();
   nf_10g_tx_metadata_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_axis ();
   nf_10g_tx_metadata #(
      .C_M_AXIS_DATA_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(DW),
      .C_S_AXIS_TUSER_WIDTH(UW), .META_DATA_WIDTH(MW)
   ) dut (
      .axis_aclk(axis_aclk), .axis_resetn(axis_resetn), .s_axis(s_axis), .m_axis(m_axis),
      .stat_fifo_full(stat_fifo_full), .stat_fifo_dout(stat_fifo_dout),
      .stat_fifo_wren(stat_fifo_wren), .dst_port_num(dst_port_num)
   );

   function automatic int mask_of(input int port);
      return (port >= 0 && port < 4) ? (1 << (2 * port)) : 1;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_cycle();
      if (m_axis.tvalid && m_axis.tready) begin
         if (exp_q.size() == 0) chk("beat_pending", exp_q.size() != 0, 1'b1);
         else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("out_beat", {m_axis.tdata, m_axis.tkeep, m_axis.tlast}, {e.d, e.k, e.l});
         end
      end else if (!m_axis.tvalid)
         chk("idle_out_zero", {m_axis.tdata, m_axis.tkeep, m_axis.tlast}, '0);
      if (stat_fifo_wren) begin
         wren_hist.push_back(cyc);
         if (rec_q.size() == 0) chk("rec_pending", rec_q.size() != 0, 1'b1);
         else chk("stat_record", stat_fifo_dout, rec_q.pop_front());
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge axis_aclk);
         s_axis.tvalid = 0; s_axis.tdata = '0; s_axis.tkeep = '0; s_axis.tlast = 0; s_axis.tuser = '0;
         stat_fifo_full = 0; m_axis.tready = 1;
         #1;
         check_cycle();
      end
   endtask

   task automatic abort_pkt();
      axis_resetn = 0;
      #1;
      chk("abort_s_tready", s_axis.tready, 1'b0);
      chk("abort_wren", stat_fifo_wren, 1'b0);
      exp_q.delete();
      void'(rec_q.pop_back());
      idle(2);
      @(negedge axis_aclk);
      axis_resetn = 1;
   endtask

   task automatic drive_pkt(input int port, input int nbytes, input int len_field, input logic [7:0] dst,
                            input bit bp, input int hold, input int abort_at, output int acc_cyc);
      int nb, idx, guard;
      bit fwd, first_chk;
      beat_t b[$];
      logic [UW-1:0] hdr;
      nb = (nbytes + KW - 1) / KW;
      for (int i = 0; i < nb; i++) begin
         beat_t t;
         int rem;
         rem = nbytes - i * KW;
         t.d = {$urandom, $urandom};
         t.k = rem >= KW ? 8'hFF : 8'((1 << rem) - 1);
         t.l = (i == nb - 1);
         b.push_back(t);
      end
      fwd = (int'(dst) & mask_of(port)) != 0;
      if (fwd) foreach (b[i]) exp_q.push_back(b[i]);
      rec_q.push_back({10'h0, 15'(nbytes > 32767 ? 32767 : nbytes), 2'b00, nbytes != len_field, !fwd, fwd});
      hdr = {$urandom, $urandom, $urandom, dst, 8'(port), 16'(len_field)};
      dst_port_num = 8'(port);
      acc_cyc = -1;
      first_chk = hold > 0;
      for (int h = 0; h < hold; h++) begin
         @(negedge axis_aclk);
         stat_fifo_full = 1;
         s_axis.tvalid = 1; s_axis.tdata = b[0].d; s_axis.tkeep = b[0].k; s_axis.tlast = b[0].l; s_axis.tuser = hdr;
         m_axis.tready = 1;
         #1;
         chk("full_s_tready", s_axis.tready, 1'b0);
         chk("full_m_tvalid", m_axis.tvalid, 1'b0);
         check_cycle();
      end
      idx = 0;
      guard = 0;
      while (idx < nb && guard < 20000) begin
         @(negedge axis_aclk);
         stat_fifo_full = 0;
         s_axis.tvalid = 1; s_axis.tdata = b[idx].d; s_axis.tkeep = b[idx].k; s_axis.tlast = b[idx].l;
         s_axis.tuser = idx == 0 ? hdr : {$urandom, $urandom, $urandom, $urandom};
         m_axis.tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (first_chk) begin
            chk("full_release_ready", s_axis.tready, 1'b1);
            first_chk = 0;
         end
         check_cycle();
         if (s_axis.tready) begin
            if (idx == 0) acc_cyc = cyc;
            idx++;
            if (abort_at > 0 && idx == abort_at) begin
               abort_pkt();
               return;
            end
         end
         guard++;
      end
      if (idx < nb) chk("pkt_timeout", idx, nb);
   endtask

   initial begin
      int a1, a2, n;
      s_axis.tvalid = 0; s_axis.tdata = '0; s_axis.tkeep = '0; s_axis.tlast = 0; s_axis.tuser = '0;
      m_axis.tready = 1;
      repeat (2) @(negedge axis_aclk);
      s_axis.tvalid = 1; s_axis.tkeep = 8'hFF; s_axis.tdata = 64'h1234; s_axis.tuser = {96'h0, 8'h01, 8'h00, 16'd64};
      #1;
      chk("rst_s_tready", s_axis.tready, 1'b0);
      chk("rst_m_tvalid", m_axis.tvalid, 1'b0);
      chk("rst_m_tdata", m_axis.tdata, '0);
      chk("rst_wren", stat_fifo_wren, 1'b0);
      chk("rst_dout", stat_fifo_dout, '0);
      @(negedge axis_aclk);
      s_axis.tvalid = 0;
      axis_resetn = 1;
      idle(2);
      drive_pkt(0, 60, 60, 8'h01, 0, 0, 0, a1);
      idle(3);
      chk("fwd_record", stat_fifo_dout, 30'h781);
      drive_pkt(0, 64, 64, 8'h04, 0, 0, 0, a1);
      idle(3);
      chk("drop_record", stat_fifo_dout, 30'h802);
      drive_pkt(2, 60, 64, 8'h10, 0, 0, 0, a1);
      idle(3);
      chk("mismatch_record", stat_fifo_dout, 30'h785);
      drive_pkt(1, 200, 200, 8'h04, 0, 10, 0, a1);
      idle(3);
      n = wren_hist.size();
      drive_pkt(3, 8, 8, 8'h40, 0, 0, 0, a1);
      drive_pkt(3, 5, 5, 8'h01, 0, 0, 0, a2);
      idle(3);
      chk("b2b_accept_gap", a2 - a1, 2);
      if (wren_hist.size() >= n + 2) begin
         chk("b2b_wren_lat", wren_hist[n] - a1, 1);
         chk("b2b_wren_gap", wren_hist[n + 1] - wren_hist[n], 2);
      end else chk("b2b_wren_count", wren_hist.size() - n, 2);
      n = wren_hist.size();
      drive_pkt(0, 200, 200, 8'h01, 0, 0, 3, a1);
      idle(5);
      chk("abort_no_record", wren_hist.size() - n, 0);
      drive_pkt(0, 60, 60, 8'h01, 0, 0, 0, a1);
      idle(3);
      for (int p = 0; p < 100; p++) begin
         int port, nbytes;
         logic [7:0] dst;
         port = $urandom_range(0, 5);
         nbytes = $urandom_range(60, 1514);
         dst = $urandom_range(0, 1) ? 8'(mask_of(port)) : 8'(1 << $urandom_range(0, 7));
         drive_pkt(port, nbytes, $urandom_range(0, 9) == 0 ? nbytes + 1 : nbytes, dst, 1, 0, 0, a1);
      end
      idle(5);
      chk("beats_left", exp_q.size(), 0);
      chk("recs_left", rec_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/nf_10g_tx_metadata.md
# nf_10g_tx_metadata

Transmit-side companion of the 10G port metadata inserter. It consumes internal AXI-Stream packets from the output queues, with per-packet metadata on `tuser` of the first beat. It forwards packets addressed to this port toward the 10G MAC TX path with `tuser` stripped, and sinks packets not addressed to this port. For every packet, forwarded or dropped, it writes one statistics record into the asynchronous stat FIFO.

## Interface
- `C_M_AXIS_DATA_WIDTH`, 64, master data width.
- `C_S_AXIS_DATA_WIDTH`, 64, slave data width; must equal master width.
- `C_S_AXIS_TUSER_WIDTH`, 128, slave tuser width.
- `META_DATA_WIDTH`, 30, stat record width.

- `axis_aclk` in 1: single clock.
- `axis_resetn` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in C_S_AXIS_DATA_WIDTH: input data.
- `s_axis_tkeep` in C_S_AXIS_DATA_WIDTH/8: byte enables, contiguous from LSB.
- `s_axis_tuser` in C_S_AXIS_TUSER_WIDTH: metadata, valid on first beat only.
  - [15:0] = byte length.
  - [23:16] = source port.
  - [31:24] = one-hot destination.
- `s_axis_tvalid` in 1, `s_axis_tready` out 1, `s_axis_tlast` in 1: input handshake and end of packet.
- `m_axis_tdata` out C_M_AXIS_DATA_WIDTH, `m_axis_tkeep` out C_M_AXIS_DATA_WIDTH/8: output data and byte enables toward the MAC.
- `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tlast` out 1: output handshake and end of packet.
- `stat_fifo_full` in 1: stat FIFO write-side full flag.
- `stat_fifo_dout` out META_DATA_WIDTH: stat record.
- `stat_fifo_wren` out 1: stat record write strobe.
- `dst_port_num` in 8: this interface's index (quasi-static).

## Operation
- Destination mask from `dst_port_num`: 0→0x01, 1→0x04, 2→0x10, 3→0x40, any other value→0x01.
- Match: `(s_axis_tuser[31:24] & mask) != 0`, evaluated on the first beat.
- State machine has four states: IDLE, SEND, DROP, STAT.
- **IDLE:**
  - All outputs are inactive while `stat_fifo_full` is 1 or `s_axis_tvalid` is 0.
  - Otherwise the first beat is treated as the header.
  - On match: the beat is passed through combinationally (`m_axis_tvalid=1`, `s_axis_tready=m_axis_tready`).
  - On no match: the beat is sunk (`s_axis_tready=1`, `m_axis_tvalid=0`).
  - On the accepting handshake:
    - Latch `s_axis_tuser[15:0]` as the expected length.
    - Load the byte counter with popcount(`s_axis_tkeep`).
    - Latch the drop flag.
  - Next state: STAT if `tlast`, else SEND on match or DROP on no match.
- **SEND:**
  - Pass-through; `m_axis_*` mirrors `s_axis_*` and `s_axis_tready=m_axis_tready`.
  - Each accepted beat adds popcount(`tkeep`) to the counter.
  - Move to STAT on an accepted `tlast`.
- **DROP:**
  - `s_axis_tready=1`, `m_axis_tvalid=0`.
  - Counting is the same as SEND; move to STAT on an accepted `tlast`.
- **STAT:**
  - Lasts exactly one cycle; no input is accepted.
  - `stat_fifo_wren` is high and `stat_fifo_dout` is valid.
  - Next state is always IDLE.
- Stat record fields:
  - [0] = forwarded.
  - [1] = dropped.
  - [2] = length mismatch (counted bytes ≠ latched length).
  - [4:3] = 0.
  - [19:5] = counted bytes.
  - [29:20] = 0.
- Byte counter: 16 bits internally, saturating at 0xFFFF. The record carries the low 15 bits, with 0x7FFF stored if the count is ≥ 0x7FFF.
- Backpressure from the stat FIFO:
  - A packet starts only when `stat_fifo_full` is 0.
  - This block is the FIFO's only writer, so one free slot stays guaranteed until its own write.
  - The STAT bubble lets the full flag update before the next packet starts.
- Outside SEND and IDLE-match, the `m_axis_*` data, keep and last outputs are 0.

## Timing
- Data path has zero latency: output is combinational from input in IDLE-match and SEND.
- `stat_fifo_wren` and `stat_fifo_dout` are registered.
  - Strobe is high for exactly one cycle: the cycle after the `tlast` handshake.
  - `stat_fifo_dout` holds its value until the next write.
- Between back-to-back packets, `s_axis_tready` is low for exactly one cycle (STAT).
- A single-beat packet goes IDLE → STAT → IDLE.
- Reset values:
  - State is IDLE.
  - Counter, latched length and flags are 0.
  - `stat_fifo_wren=0`, `stat_fifo_dout=0`.
  - All `m_axis_*` outputs and `s_axis_tready` are 0.
- Reset mid-packet:
  - Any pending record is discarded and no write is issued.
  - The next valid beat after release is treated as a header, so upstream must be reset in the same domain.
- `m_axis_tready` low in SEND stalls input; a beat is counted only on a `tvalid & tready` cycle.

## Test plan
- Port 0, dst 0x01, length 60:
  - Stimulus: 8 beats, last `tkeep` 0x0F.
  - Required: 8 identical output beats, `tlast` on beat 8, and one `wren` with `dout` = {10'h0, 15'd60, 5'b00001}.
- Port 0, dst 0x04, length 64:
  - Required: `m_axis_tvalid` never asserted, all 8 beats accepted, and the record has count 64 with flags 5'b00010.
- Port 2, dst 0x10:
  - Stimulus: `tuser` length 64, but only 60 bytes sent.
  - Required: packet is forwarded, and the record has count 60 with flags 5'b00101.
- Stat FIFO full:
  - Stimulus: `stat_fifo_full=1` for 10 cycles with a packet pending.
  - Required: `s_axis_tready=0` and `m_axis_tvalid=0` throughout; the packet starts on the first cycle after `full` drops.
- Output backpressure:
  - Stimulus: random `m_axis_tready` (50%) over 100 packets of 60–1514 bytes.
  - Required: scoreboard shows no lost or duplicated beats, and each record count equals the bytes sent.
- Back-to-back:
  - Stimulus: two single-beat packets on consecutive valid cycles.
  - Required: exactly one `s_axis_tready`-low cycle between them and two `wren` pulses two cycles apart.
  - Also: asserting reset mid-packet produces no record.
